mdu_div: RTL and testbench
==========================

MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is verified.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request a new operation; sampled in IDLE only.
REQ-005 signed_op  in  1  1 = DIV/MULT, 0 = DIVU/MULTU.
REQ-006 mul_op  in  1  1 = multiply; honoured only with MDU_MULT_EN.
REQ-007 a  in  WIDTH  dividend or multiplicand (rs).
REQ-008 b  in  WIDTH  divisor or multiplier (rt).
REQ-009 cancel  in  1  pipeline flush; aborts any operation in flight.
REQ-010 busy  out  1  high in DIV and DONE; the pipeline stalls MFHI/MFLO on it.
REQ-011 valid  out  1  one-cycle pulse when hi_out and lo_out carry a new result.
REQ-012 hi_out  out  WIDTH  remainder, or product high half.
REQ-013 lo_out  out  WIDTH  quotient, or product low half.
REQ-014 div_zero  out  1  pulses with valid when the divisor was 0.

Function
REQ-015 The FSM SHALL have states IDLE, DIV and DONE.
REQ-016 Start acceptance: IDLE with start=1 and cancel=0 latches a, b, signed_op and mul_op, then enters DIV with iteration counter = WIDTH-1.
REQ-017 DIV SHALL perform one restoring radix-2 step per cycle; after the counter-0 step it SHALL enter DONE.
REQ-018 Latency: valid SHALL be high exactly WIDTH+1 cycles after the start edge (33 cycles at WIDTH=32); in DONE the state returns to IDLE on the next edge.
REQ-019 Signed division SHALL operate on magnitudes. Quotient sign = a[MSB]^b[MSB]. Remainder sign = a[MSB]. Magnitudes are restored by two's-complement negation in DONE.
REQ-020 Overflow case: signed 0x80000000 / 0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0 with no flag.
REQ-021 Divisor = 0: skip DIV and enter DONE on the next edge. Result: lo_out=all ones, hi_out=a, div_zero=1 with valid.
REQ-022 hi_out and lo_out SHALL update only on the edge that enters DONE and SHALL hold their value otherwise.
REQ-023 start SHALL be ignored while busy=1, with no queuing.
REQ-024 cancel=1 in DIV or DONE SHALL force IDLE on the next edge and suppress valid; hi_out and lo_out keep their prior values.
REQ-025 cancel and start high together in IDLE: cancel SHALL win, and the operation is not accepted.
REQ-026 Back-to-back operation: a start is accepted in the first IDLE cycle after DONE, so the minimum issue interval is WIDTH+2 cycles.

Reset
REQ-027 resetn low SHALL asynchronously force IDLE and clear the counter, busy, valid, div_zero, hi_out, lo_out and all latched operands to 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation with no valid pulse; the first start after release behaves as from power-up.

Configuration
REQ-029 Macro MDU_MULT_EN defined: a start with mul_op=1 SHALL compute the signed or unsigned 2*WIDTH-bit product and enter DONE on the next edge. {hi_out,lo_out} = product, latency 2 cycles, div_zero=0.
REQ-030 MDU_MULT_EN undefined: mul_op SHALL be ignored, every operation is a division, and no multiplier logic is synthesised.

Structure
REQ-031 Package mdu_pkg SHALL hold: the state enum (IDLE, DIV, DONE), the WIDTH default constant, and the divide-by-zero result constants.
REQ-032 Sub-module mdu_div_step SHALL implement one combinational restoring iteration: partial remainder, divisor, next dividend bit in; new partial remainder and quotient bit out.

Verification
REQ-033 DIVU 100/7 -> valid at cycle 33 after start, lo_out=14, hi_out=2, div_zero=0.
REQ-034 DIV -7/2 (0xFFFFFFF9 / 2) -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1).
REQ-035 DIV 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. DIVU 5/0 -> valid 2 cycles after start, lo_out=0xFFFFFFFF, hi_out=5, div_zero=1.
REQ-036 Start 50/5, cancel at cycle 10 -> no valid, hi_out and lo_out unchanged. A new start at cycle 12 of 9/4 -> lo_out=2, hi_out=1.
REQ-037 resetn low at cycle 20 of a division -> all outputs 0 at once, no valid. A start while busy is ignored, checked by a second start at cycle 5.
REQ-038 With MDU_MULT_EN: MULT 0xFFFFFFFF x 2 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFE, valid 2 cycles after start. MULTU with the same operands -> hi_out=1, lo_out=0xFFFFFFFE.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the MIPS-style divide/multiply unit.
// State encoding, default width and divide-by-zero result values.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Quotient returned for a zero divisor; the remainder is the dividend.
   localparam logic [MDU_WIDTH-1:0] DZ_QUO  = '1;
   localparam logic                 DZ_FLAG = 1'b1;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring radix-2 division iteration, purely combinational.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {1'b0, div_i};
      q_o     = ~diff[WIDTH];
      rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   end

endmodule

// File: rtl/mdu_div.sv
// Iterative 32-cycle HI/LO divider with optional single-cycle multiplier.
// Define MDU_MULT_EN to enable MULT/MULTU via mul_op.
module mdu_div
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             signed_op,
   input  logic             mul_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             valid_q;
   logic             dz_q;
   logic             dzp_q;
   logic             sgn_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic [WIDTH-1:0] quo_fin;
   logic [WIDTH-1:0] lo_fin;
   logic [WIDTH-1:0] hi_fin;
   logic             qneg;
   logic             rneg;

`ifdef MDU_MULT_EN
   logic             mul_q;
   logic [2*WIDTH-1:0] pa;
   logic [2*WIDTH-1:0] pb;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      pa   = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
      pb   = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
      prod = pa * pb;
   end
`else
   logic unused_mul;
   assign unused_mul = mul_op;
`endif

   mdu_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i (rem_q),
      .div_i (dsr_q),
      .bit_i (dvd_q[WIDTH-1]),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // Sign of each result follows from the raw latched operands.
   always_comb begin
      a_mag   = (signed_op & a[WIDTH-1]) ? -a : a;
      b_mag   = (signed_op & b[WIDTH-1]) ? -b : b;
      qneg    = sgn_q & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
      rneg    = sgn_q & opa_q[WIDTH-1];
      quo_fin = {dvd_q[WIDTH-2:0], step_q};
      lo_fin  = qneg ? -quo_fin : quo_fin;
      hi_fin  = rneg ? -step_rem : step_rem;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         dz_q    <= 1'b0;
         dzp_q   <= 1'b0;
         sgn_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MDU_MULT_EN
         mul_q   <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         dz_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && !cancel) begin
                  state_q <= DIV;
                  busy_q  <= 1'b1;
                  cnt_q   <= CW'(WIDTH - 1);
                  sgn_q   <= signed_op;
                  opa_q   <= a;
                  opb_q   <= b;
                  dvd_q   <= a_mag;
                  dsr_q   <= b_mag;
                  rem_q   <= '0;
                  dzp_q   <= 1'b0;
`ifdef MDU_MULT_EN
                  mul_q   <= mul_op;
`endif
               end
            end
            DIV: begin
               if (cancel) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
`ifdef MDU_MULT_EN
               else if (mul_q) begin
                  state_q <= DONE;
                  hi_q    <= prod[2*WIDTH-1:WIDTH];
                  lo_q    <= prod[WIDTH-1:0];
               end
`endif
               else if (opb_q == '0) begin
                  state_q <= DONE;
                  hi_q    <= opa_q;
                  lo_q    <= WIDTH'(DZ_QUO);
                  dzp_q   <= DZ_FLAG;
               end else begin
                  rem_q <= step_rem;
                  dvd_q <= quo_fin;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == '0) begin
                     state_q <= DONE;
                     hi_q    <= hi_fin;
                     lo_q    <= lo_fin;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (!cancel) begin
                  valid_q <= 1'b1;
                  dz_q    <= dzp_q;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_mdu_div.sv
// Directed self-checking bench for mdu_div.
// Build with +define+MDU_MULT_EN to exercise the multiplier path.
module tb_mdu_div;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        signed_op;
   logic        mul_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        valid;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_zero;

   int errors = 0;
   int checks = 0;

   mdu_div #(.WIDTH(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .signed_op (signed_op),
      .mul_op    (mul_op),
      .a         (a),
      .b         (b),
      .cancel    (cancel),
      .busy      (busy),
      .valid     (valid),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called 1ns after an edge; the next edge is the start edge.
   task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                        input logic s, input logic m);
      a = va; b = vb; signed_op = s; mul_op = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Cycles from the start edge to the first valid; 0 if none within bound.
   task automatic wait_valid(input int limit, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      for (int k = 1; k <= limit; k++) begin
         if (!seen) begin
            @(posedge clk); #1;
            if (valid) begin
               seen = 1'b1;
               lat  = k;
            end
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; cancel = 1'b0;
      signed_op = 1'b0; mul_op = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, valid, div_zero} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 000", {busy, valid, div_zero});
      end
      checks++;
      if ({hi_out, lo_out} !== 64'h0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0", {hi_out, lo_out});
      end
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_divu();
      int lat;
      issue(32'd100, 32'd7, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL divu_busy: got %b want 1", busy);
      end
      wait_valid(40, lat);
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL divu_latency: got %0d want 33", lat);
      end
      checks++;
      if ({hi_out, lo_out, div_zero} !== {32'd2, 32'd14, 1'b0}) begin
         errors++;
         $display("FAIL divu_100_7: got hi=%h lo=%h dz=%b want hi=2 lo=e dz=0",
                  hi_out, lo_out, div_zero);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL divu_busy_end: got %b want 0", busy);
      end
      @(posedge clk); #1;
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL divu_pulse: got %b want 0", valid);
      end
   endtask

   task automatic test_div_signed();
      int lat;
      issue(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
      wait_valid(40, lat);
      checks++;
      if ({lat, hi_out, lo_out} !== {32'd33, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
         errors++;
         $display("FAIL div_m7_2: got lat=%0d hi=%h lo=%h want 33 ffffffff fffffffd",
                  lat, hi_out, lo_out);
      end
      issue(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
      wait_valid(40, lat);
      checks++;
      if ({hi_out, lo_out} !== {32'd1, 32'hFFFFFFFD}) begin
         errors++;
         $display("FAIL div_7_m2: got hi=%h lo=%h want 1 fffffffd", hi_out, lo_out);
      end
   endtask

   task automatic test_overflow();
      int lat;
      issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
      wait_valid(40, lat);
      checks++;
      if ({hi_out, lo_out, div_zero} !== {32'h0, 32'h80000000, 1'b0}) begin
         errors++;
         $display("FAIL div_ovf: got hi=%h lo=%h dz=%b want 0 80000000 0",
                  hi_out, lo_out, div_zero);
      end
   endtask

   task automatic test_div_zero();
      int lat;
      issue(32'd5, 32'd0, 1'b0, 1'b0);
      wait_valid(40, lat);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL dz_latency: got %0d want 2", lat);
      end
      checks++;
      if ({hi_out, lo_out, div_zero} !== {32'd5, 32'hFFFFFFFF, 1'b1}) begin
         errors++;
         $display("FAIL divu_5_0: got hi=%h lo=%h dz=%b want 5 ffffffff 1",
                  hi_out, lo_out, div_zero);
      end
      issue(32'hFFFFFFFB, 32'd0, 1'b1, 1'b0);
      wait_valid(40, lat);
      checks++;
      if ({hi_out, lo_out, div_zero} !== {32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1}) begin
         errors++;
         $display("FAIL div_m5_0: got hi=%h lo=%h dz=%b want fffffffb ffffffff 1",
                  hi_out, lo_out, div_zero);
      end
   endtask

   // Follows test_div_zero: outputs hold fffffffb / ffffffff.
   task automatic test_cancel();
      int lat;
      int vcount;
      vcount = 0;
      issue(32'd50, 32'd5, 1'b0, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         if (valid) vcount++;
      end
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      if (valid) vcount++;
      checks++;
      if ({busy, hi_out, lo_out} !== {1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF}) begin
         errors++;
         $display("FAIL cancel_hold: got busy=%b hi=%h lo=%h want 0 fffffffb ffffffff",
                  busy, hi_out, lo_out);
      end
      @(posedge clk); #1;
      if (valid) vcount++;
      issue(32'd9, 32'd4, 1'b0, 1'b0);
      wait_valid(40, lat);
      checks++;
      if (vcount !== 0) begin
         errors++;
         $display("FAIL cancel_valid: got %0d pulses want 0", vcount);
      end
      checks++;
      if ({lat, hi_out, lo_out} !== {32'd33, 32'd1, 32'd2}) begin
         errors++;
         $display("FAIL cancel_next: got lat=%0d hi=%h lo=%h want 33 1 2",
                  lat, hi_out, lo_out);
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      int extra;
      extra = 0;
      issue(32'd100, 32'd7, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      issue(32'd9, 32'd4, 1'b0, 1'b0);
      wait_valid(40, lat);
      checks++;
      if ({lat, hi_out, lo_out} !== {32'd28, 32'd2, 32'd14}) begin
         errors++;
         $display("FAIL busy_ignore: got lat=%0d hi=%h lo=%h want 28 2 e",
                  lat, hi_out, lo_out);
      end
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (valid) extra++;
      end
      checks++;
      if (extra !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_queue: got %0d pulses busy=%b want 0 0", extra, busy);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int vcount;
      vcount = 0;
      issue(32'd1000, 32'd3, 1'b0, 1'b0);
      repeat (19) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      checks++;
      if ({busy, valid, div_zero, hi_out, lo_out} !== 67'h0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b v=%b dz=%b hi=%h lo=%h want all 0",
                  busy, valid, div_zero, hi_out, lo_out);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (valid || busy) vcount++;
      end
      issue(32'd9, 32'd4, 1'b0, 1'b0);
      wait_valid(40, lat);
      checks++;
      if ({vcount, lat, hi_out, lo_out} !== {32'd0, 32'd33, 32'd1, 32'd2}) begin
         errors++;
         $display("FAIL reset_restart: got stray=%0d lat=%0d hi=%h lo=%h want 0 33 1 2",
                  vcount, lat, hi_out, lo_out);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(32'd77, 32'd10, 1'b0, 1'b0);
      wait_valid(40, lat);
      checks++;
      if ({lat, hi_out, lo_out} !== {32'd33, 32'd7, 32'd7}) begin
         errors++;
         $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h want 33 7 7",
                  lat, hi_out, lo_out);
      end
      issue(32'hFFFFFF9C, 32'd7, 1'b1, 1'b0);
      wait_valid(40, lat);
      checks++;
      if ({lat, hi_out, lo_out} !== {32'd33, 32'hFFFFFFFE, 32'hFFFFFFF2}) begin
         errors++;
         $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h want 33 fffffffe fffffff2",
                  lat, hi_out, lo_out);
      end
   endtask

   task automatic test_mul_op();
      int lat;
`ifdef MDU_MULT_EN
      issue(32'hFFFFFFFF, 32'd2, 1'b1, 1'b1);
      wait_valid(40, lat);
      checks++;
      if ({lat, hi_out, lo_out, div_zero} !==
          {32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}) begin
         errors++;
         $display("FAIL mult: got lat=%0d hi=%h lo=%h dz=%b want 2 ffffffff fffffffe 0",
                  lat, hi_out, lo_out, div_zero);
      end
      issue(32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
      wait_valid(40, lat);
      checks++;
      if ({lat, hi_out, lo_out} !== {32'd2, 32'd1, 32'hFFFFFFFE}) begin
         errors++;
         $display("FAIL multu: got lat=%0d hi=%h lo=%h want 2 1 fffffffe",
                  lat, hi_out, lo_out);
      end
`else
      issue(32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
      wait_valid(40, lat);
      checks++;
      if ({lat, hi_out, lo_out} !== {32'd33, 32'd1, 32'h7FFFFFFF}) begin
         errors++;
         $display("FAIL mul_ignored: got lat=%0d hi=%h lo=%h want 33 1 7fffffff",
                  lat, hi_out, lo_out);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_divu();
      test_div_signed();
      test_overflow();
      test_div_zero();
      test_cancel();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_mul_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
